d_victim_cache_ctrl: RTL and testbench

D_VICTIM_CACHE_CTRL -- requirements
Module: d_victim_cache_ctrl

---
 rtl/d_victim_cache_ctrl.sv | 122 ++++++++++++
 tb/tb_d_victim_cache_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/d_victim_cache_ctrl.sv
// d_victim_cache_ctrl: 8-way victim cache tag/valid/dirty controller with dirty-victim writeback
module d_victim_cache_ctrl #(
  parameter int INDEX_VC = 2,
  parameter int WAYS = 8,
  parameter int TAG_W = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_op_i,
  input  logic [INDEX_VC-1:0] req_index_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  input  logic                req_dirty_i,
  output logic                rsp_valid_o,
  output logic                rsp_hit_o,
  output logic [2:0]          rsp_way_o,
  output logic                plru_valid_o,
  output logic [INDEX_VC-1:0] plru_index_o,
  output logic [2:0]          plru_way_o,
  input  logic [2:0]          plru_victim_i,
  output logic                data_re_o,
  output logic                data_we_o,
  output logic [INDEX_VC-1:0] data_index_o,
  output logic [2:0]          data_way_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [INDEX_VC-1:0] wb_index_o,
  output logic [TAG_W-1:0]    wb_tag_o,
  output logic                busy_o
);
  localparam int SETS = 1 << INDEX_VC;
  typedef enum logic [1:0] {IDLE, CMP, WB, WRITE} state_t;
  state_t state;
  logic op_q, dirty_q, hit_q;
  logic [INDEX_VC-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [2:0] sel_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tags;
  logic [SETS-1:0][WAYS-1:0] valid, dirty;
  logic [WAYS-1:0] hit_vec;
  logic [2:0] hit_way, inv_way, sel_way, way_out;
  logic hit, has_inv, victim_dirty, in_cmp, in_wb, in_wr, lk_hit;
  // Scan high-to-low so the lowest matching / invalid way wins
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      hit_vec[i] = valid[idx_q][i] && (tags[idx_q][i] == tag_q);
      if (hit_vec[i]) hit_way = 3'(i);
      if (!valid[idx_q][i]) inv_way = 3'(i);
    end
  end
  assign hit = |hit_vec;
  assign has_inv = ~&valid[idx_q];
  assign sel_way = hit ? hit_way : has_inv ? inv_way : plru_victim_i;
  assign victim_dirty = valid[idx_q][sel_way] & dirty[idx_q][sel_way] & ~hit;
  assign in_cmp = state == CMP;
  assign in_wb = state == WB;
  assign in_wr = state == WRITE;
  assign lk_hit = in_cmp & ~op_q & hit;
  assign way_out = lk_hit ? hit_way : in_wr ? sel_q : 3'd0;
  assign req_ready_o = (state == IDLE) & ~rst_i;
  assign busy_o = state != IDLE;
  assign rsp_valid_o = (in_cmp & ~op_q) | in_wr;
  assign rsp_hit_o = lk_hit | (in_wr & hit_q);
  assign rsp_way_o = way_out;
  assign plru_valid_o = lk_hit | in_wr;
  assign plru_index_o = idx_q;
  assign plru_way_o = way_out;
  assign data_re_o = lk_hit | in_wb;
  assign data_we_o = in_wr;
  assign data_index_o = idx_q;
  assign data_way_o = lk_hit ? hit_way : (in_wb | in_wr) ? sel_q : 3'd0;
  assign wb_valid_o = in_wb;
  assign wb_index_o = in_wb ? idx_q : '0;
  assign wb_tag_o = in_wb ? tags[idx_q][sel_q] : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      op_q <= 1'b0;
      dirty_q <= 1'b0;
      hit_q <= 1'b0;
      idx_q <= '0;
      tag_q <= '0;
      sel_q <= '0;
      tags <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          op_q <= req_op_i;
          idx_q <= req_index_i;
          tag_q <= req_tag_i;
          dirty_q <= req_dirty_i;
          state <= CMP;
        end
        CMP: if (!op_q) begin
          // A lookup hit hands the line back to L1, so the entry is freed
          if (hit) begin
            valid[idx_q][hit_way] <= 1'b0;
            dirty[idx_q][hit_way] <= 1'b0;
          end
          state <= IDLE;
        end else begin
          sel_q <= sel_way;
          hit_q <= hit;
          state <= victim_dirty ? WB : WRITE;
        end
        WB: if (wb_ready_i) state <= WRITE;
        WRITE: begin
          tags[idx_q][sel_q] <= tag_q;
          valid[idx_q][sel_q] <= 1'b1;
          dirty[idx_q][sel_q] <= dirty_q | (hit_q & dirty[idx_q][sel_q]);
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_d_victim_cache_ctrl.sv
// tb_d_victim_cache_ctrl: directed vector table, corner sequences and randomized model comparison
module tb_d_victim_cache_ctrl;
  logic clk_i = 0, rst_i = 1, req_valid_i = 0, req_op_i = 0, req_dirty_i = 0, wb_ready_i = 0;
  logic [1:0] req_index_i = 0;
  logic [19:0] req_tag_i = 0;
  logic [2:0] plru_victim_i = 0;
  logic req_ready_o, rsp_valid_o, rsp_hit_o, plru_valid_o, data_re_o, data_we_o, wb_valid_o, busy_o;
  logic [2:0] rsp_way_o, plru_way_o, data_way_o;
  logic [1:0] plru_index_o, data_index_o, wb_index_o;
  logic [19:0] wb_tag_o;
  int checks = 0, failures = 0;
  bit mv[4][8], md[4][8];
  logic [19:0] mt[4][8];

  typedef struct {
    logic op; logic [1:0] idx; logic [19:0] tag; logic d; logic [2:0] vic; int wbw;
    logic hit; logic [2:0] way; logic wb; logic [19:0] wbt;
  } vec_t;
  vec_t tv[$];

  d_victim_cache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_index_i(req_index_i), .req_tag_i(req_tag_i), .req_dirty_i(req_dirty_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o),
    .plru_valid_o(plru_valid_o), .plru_index_o(plru_index_o), .plru_way_o(plru_way_o),
    .plru_victim_i(plru_victim_i), .data_re_o(data_re_o), .data_we_o(data_we_o),
    .data_index_o(data_index_o), .data_way_o(data_way_o), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_index_o(wb_index_o), .wb_tag_o(wb_tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference: victim cache behaviour expressed on plain per-way arrays
  task automatic mdl(input logic op, input logic [1:0] idx, input logic [19:0] tag, input logic d,
                     input logic [2:0] vic, output logic e_hit, output logic [2:0] e_way,
                     output logic e_wb, output logic [19:0] e_wbt);
    int w = -1;
    for (int i = 0; i < 8; i++) if (w < 0 && mv[idx][i] && mt[idx][i] == tag) w = i;
    e_hit = w >= 0;
    e_wb = 0;
    e_wbt = 0;
    if (!op) begin
      e_way = e_hit ? 3'(w) : 3'd0;
      if (e_hit) begin mv[idx][w] = 0; md[idx][w] = 0; end
    end else begin
      for (int i = 0; i < 8; i++) if (w < 0 && !mv[idx][i]) w = i;
      if (w < 0) w = int'(vic);
      e_way = 3'(w);
      e_wb = mv[idx][w] && md[idx][w] && !e_hit;
      e_wbt = e_wb ? mt[idx][w] : 20'h0;
      md[idx][w] = d | (e_hit & md[idx][w]);
      mv[idx][w] = 1;
      mt[idx][w] = tag;
    end
  endtask

  task automatic txn(input logic op, input logic [1:0] idx, input logic [19:0] tag, input logic d,
                     input logic [2:0] vic, input int wbw, output logic hit, output logic [2:0] way,
                     output logic wb, output logic [19:0] wbt);
    int lat = 0, n = 0;
    logic done = 0;
    logic [2:0] wb_way = 0;
    hit = 0; way = 0; wb = 0; wbt = 0;
    req_valid_i = 1; req_op_i = op; req_index_i = idx; req_tag_i = tag; req_dirty_i = d;
    plru_victim_i = vic;
    wb_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    chk("ready_idle", req_ready_o, 1);
    @(posedge clk_i);
    #1 req_valid_i = 0;
    while (!done && lat < 60) begin
      @(negedge clk_i);
      lat++;
      chk("busy", busy_o, 1);
      chk("ready_busy", req_ready_o, 0);
      chk("plru_index", plru_index_o, idx);
      chk("data_index", data_index_o, idx);
      if (wb_valid_o) begin
        if (wb) chk("wb_tag_stable", wb_tag_o, wbt);
        else begin wbt = wb_tag_o; wb_way = data_way_o; end
        wb = 1;
        chk("wb_index", wb_index_o, idx);
        chk("wb_data_re", data_re_o, 1);
        chk("wb_data_way", data_way_o, wb_way);
        wb_ready_i = (n == wbw);
        n++;
      end else wb_ready_i = 1'($urandom_range(0, 1));
      if (rsp_valid_o) begin
        done = 1;
        hit = rsp_hit_o;
        way = rsp_way_o;
        chk("rsp_plru_valid", plru_valid_o, op | hit);
        chk("rsp_data_we", data_we_o, op);
        chk("rsp_data_re", data_re_o, !op & hit);
        if (op | hit) begin
          chk("rsp_plru_way", plru_way_o, way);
          chk("rsp_data_way", data_way_o, way);
        end
        if (wb) chk("wb_way_vs_rsp", wb_way, way);
        chk("latency", lat, op ? (wb ? 3 + wbw : 2) : 1);
      end
    end
    if (!done) chk("rsp_timeout", 0, 1);
    wb_ready_i = 0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic h, b, eh, eb, op, d;
    logic [2:0] w, ew, vic;
    logic [19:0] t, et, tag;
    logic [1:0] idx;
    int n, wbw;
    // Reset state
    @(negedge clk_i);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_strobes", {plru_valid_o, data_re_o, data_we_o}, 0);
    @(posedge clk_i);
    #1 rst_i = 0;
    #1 chk("ready_after_rst", req_ready_o, 1);

    tv.push_back('{1'b0, 2'd1, 20'hABC, 1'b0, 3'd0, 0, 1'b0, 3'd0, 1'b0, 20'h0});
    tv.push_back('{1'b1, 2'd1, 20'hABC, 1'b0, 3'd0, 0, 1'b0, 3'd0, 1'b0, 20'h0});
    tv.push_back('{1'b0, 2'd1, 20'hABC, 1'b0, 3'd0, 0, 1'b1, 3'd0, 1'b0, 20'h0});
    tv.push_back('{1'b0, 2'd1, 20'hABC, 1'b0, 3'd0, 0, 1'b0, 3'd0, 1'b0, 20'h0});
    for (int i = 0; i < 8; i++)
      tv.push_back('{1'b1, 2'd2, 20'(32'h100 + i), 1'b1, 3'd0, 0, 1'b0, 3'(i), 1'b0, 20'h0});
    tv.push_back('{1'b1, 2'd2, 20'h200, 1'b1, 3'd5, 3, 1'b0, 3'd5, 1'b1, 20'h105});
    tv.push_back('{1'b1, 2'd2, 20'h103, 1'b0, 3'd0, 0, 1'b1, 3'd3, 1'b0, 20'h0});
    tv.push_back('{1'b1, 2'd2, 20'h300, 1'b0, 3'd3, 0, 1'b0, 3'd3, 1'b1, 20'h103});
    tv.push_back('{1'b0, 2'd2, 20'h200, 1'b0, 3'd0, 0, 1'b1, 3'd5, 1'b0, 20'h0});
    tv.push_back('{1'b1, 2'd2, 20'h400, 1'b0, 3'd7, 0, 1'b0, 3'd5, 1'b0, 20'h0});
    foreach (tv[k]) begin
      mdl(tv[k].op, tv[k].idx, tv[k].tag, tv[k].d, tv[k].vic, eh, ew, eb, et);
      txn(tv[k].op, tv[k].idx, tv[k].tag, tv[k].d, tv[k].vic, tv[k].wbw, h, w, b, t);
      chk($sformatf("tv%0d_hit", k), h, tv[k].hit);
      chk($sformatf("tv%0d_way", k), w, tv[k].way);
      chk($sformatf("tv%0d_wb", k), b, tv[k].wb);
      chk($sformatf("tv%0d_wbtag", k), t, tv[k].wbt);
    end

    // Reset while a writeback is pending
    for (int i = 0; i < 8; i++) begin
      mdl(1'b1, 2'd0, 20'(32'h500 + i), 1'b1, 3'd0, eh, ew, eb, et);
      txn(1'b1, 2'd0, 20'(32'h500 + i), 1'b1, 3'd0, 0, h, w, b, t);
      chk("fill0_way", w, ew);
    end
    req_valid_i = 1; req_op_i = 1; req_index_i = 0; req_tag_i = 20'h5FF; req_dirty_i = 1;
    plru_victim_i = 3'd2; wb_ready_i = 0;
    @(posedge clk_i);
    #1 req_valid_i = 0;
    n = 0;
    while (!wb_valid_o && n < 10) begin @(negedge clk_i); n++; end
    chk("wb_reached", wb_valid_o, 1);
    chk("wb_reached_tag", wb_tag_o, 20'h502);
    #2 rst_i = 1;
    #1;
    chk("rst_wb_drop", wb_valid_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_ready", req_ready_o, 0);
    chk("rst_mid_rsp", {rsp_valid_o, data_we_o, data_re_o}, 0);
    @(posedge clk_i);
    #1 rst_i = 0;
    foreach (mv[s, i]) begin mv[s][i] = 0; md[s][i] = 0; end
    for (int i = 0; i < 9; i++) begin
      tag = (i == 8) ? 20'h5FF : 20'(32'h500 + i);
      txn(1'b0, 2'd0, tag, 1'b0, 3'd0, 0, h, w, b, t);
      chk("post_rst_miss", h, 0);
    end
    txn(1'b0, 2'd2, 20'h400, 1'b0, 3'd0, 0, h, w, b, t);
    chk("post_rst_miss2", h, 0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 2) != 0;
      idx = 2'($urandom_range(0, 3));
      tag = 20'(32'h700 + $urandom_range(0, 11));
      d = 1'($urandom_range(0, 1));
      vic = 3'($urandom_range(0, 7));
      wbw = $urandom_range(0, 2);
      mdl(op, idx, tag, d, vic, eh, ew, eb, et);
      txn(op, idx, tag, d, vic, wbw, h, w, b, t);
      chk($sformatf("rnd%0d_hit", k), h, eh);
      chk($sformatf("rnd%0d_way", k), w, ew);
      chk($sformatf("rnd%0d_wb", k), b, eb);
      chk($sformatf("rnd%0d_wbtag", k), t, et);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
